pipe_hazard_scoreboard: RTL and testbench
=========================================

// Module: pipe_hazard_scoreboard
// PURPOSE
//  Parametrised RAW-hazard scoreboard and forwarding unit for the deep MIPS pipeline (8-stage and deeper).
//  - Tracks destination tags of in-flight instructions through DEPTH slots, from issue (ID->EX) to register-file write.
//  - For each instruction at issue: selects forwarded operands, or stalls issue until the producing value exists.
//  - Handles branch flush, global hold and a stall performance counter.
// PARAMETERS
//  DEPTH        6   tracked slots; slot k = instruction issued k+1 accepted cycles ago; slot DEPTH-1 writes the RF
//  REG_AW       5   register-address width
//  DATA_W       32  datapath width
//  RESULT_SLOT  0   first slot whose slot_data is valid for ALU producers
//  LOAD_SLOT    1   first slot whose slot_data is valid for loads; LOAD_SLOT >= RESULT_SLOT
//  BR_SLOT      2   flush invalidates slots 0..BR_SLOT-1; 0 <= BR_SLOT <= DEPTH
//  SEL_W        3   select width; $clog2(DEPTH+1)
// PORTS
//  clk            in   1               clock, rising edge
//  reset          in   1               synchronous, active-high
//  hold           in   1               freeze all state (e.g. memory wait)
//  flush          in   1               branch taken: kill younger in-flight instructions
//  issue_valid    in   1               instruction present at issue
//  issue_rs       in   REG_AW          source register A
//  issue_rt       in   REG_AW          source register B
//  issue_rs_used  in   1               source A is read
//  issue_rt_used  in   1               source B is read
//  issue_wr_en    in   1               instruction writes a register
//  issue_wr_reg   in   REG_AW          destination register
//  issue_is_load  in   1               destination value comes from memory
//  rf_rs_data     in   DATA_W          register-file read, source A
//  rf_rt_data     in   DATA_W          register-file read, source B
//  slot_data      in   DEPTH*DATA_W    result value per slot; slot k at bits [k*DATA_W +: DATA_W]
//  stall          out  1               issue not accepted this cycle
//  fwd_rs_sel     out  SEL_W           0 = RF; k+1 = slot k
//  fwd_rt_sel     out  SEL_W           0 = RF; k+1 = slot k
//  rs_data        out  DATA_W          resolved operand A
//  rt_data        out  DATA_W          resolved operand B
//  stall_count    out  16              saturating count of stall cycles
// BEHAVIOUR
//  - Per slot state: valid, wr_en, wr_reg, is_load.
//  - Reset:
//    - all slots invalid
//    - stall_count = 0
//    - combinational outputs follow the empty state: stall=0, sel=0, data=RF.
//  - Match for a source:
//    - match = slot valid & wr_en & wr_reg==src & src!=0 & src_used.
//    - The lowest matching index k (youngest) wins; older matches are ignored.
//  - Availability: k >= (is_load ? LOAD_SLOT : RESULT_SLOT) -> forward, sel = k+1, data = slot_data[k].
//  - Otherwise hazard on that source; no match -> sel = 0, data = RF.
//  - stall = issue_valid & (hazard_rs | hazard_rt) & ~flush; purely combinational, same cycle.
//    - Stall also forces sel = 0.
//  - Chain update at posedge when ~hold:
//    - slot[k] <= slot[k-1] for k>=1.
//    - slot[0] <= issue fields if issue_valid & ~stall & ~flush, else a bubble (valid=0).
//    - The instruction leaving slot DEPTH-1 is dropped (it is written to the RF that edge).
//  - RF has no write-through: slot DEPTH-1 is forwardable like any other slot.
//  - flush (when ~hold):
//    - after the shift, slots 0..BR_SLOT-1 are invalid;
//    - the issue instruction is dropped;
//    - older slots shift normally.
//  - hold=1: no state changes (flush and issue ignored); outputs still computed combinationally.
//    - stall_count does not increment during hold.
//  - stall_count: +1 per non-hold cycle with stall=1; saturates at 16'hFFFF.
//  - Simultaneous flush & hazard: flush wins, stall=0, no count.
//  - Reset mid-operation: all in-flight tags are discarded at that edge.
//    - The datapath must flush its own pipeline registers on the same reset.
//  - Register 0 is never tracked as a hazard or forward source.
// TESTING
//  - Reset with garbage on inputs -> stall=0, sel=0, stall_count=0, rs_data=rf_rs_data.
//  - add r3 issued, then a consumer of r3 next cycle (default params)
//    -> no stall, fwd_rs_sel=1, rs_data=slot_data[0].
//  - lw r5, then a consumer of r5 next cycle -> 1 stall cycle;
//    the following cycle fwd_rt_sel=2, rt_data=slot_data[1]; stall_count=1.
//  - r7 written by slots 1 and 4 -> sel=2 (youngest wins); source r0 with a pending r0 writer -> sel=0.
//  - lw r2 in slot 0 plus flush with issue_valid=1 & hazard -> stall=0;
//    next cycle slots 0..1 empty and the consumer's sel=0.
//  - hold=1 for 3 cycles while a hazard is pending -> state frozen, stall stays 1, stall_count unchanged;
//    release -> resolves as normal.
//  - Force 65536+ stall cycles -> stall_count holds at 16'hFFFF.
//  - Params DEPTH=9, LOAD_SLOT=3: load followed by a consumer -> 3 stall cycles, then sel=4.

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_scoreboard
//  Brief    : RAW-hazard scoreboard and operand-forwarding select for a deep
//             in-order pipeline; tracks DEPTH in-flight destination tags.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_scoreboard #(
    parameter int DEPTH       = 6,
    parameter int REG_AW      = 5,
    parameter int DATA_W      = 32,
    parameter int RESULT_SLOT = 0,
    parameter int LOAD_SLOT   = 1,
    parameter int BR_SLOT     = 2,
    parameter int SEL_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic [REG_AW-1:0]       issue_rs,
    input  logic [REG_AW-1:0]       issue_rt,
    input  logic                    issue_rs_used,
    input  logic                    issue_rt_used,
    input  logic                    issue_wr_en,
    input  logic [REG_AW-1:0]       issue_wr_reg,
    input  logic                    issue_is_load,
    input  logic [DATA_W-1:0]       rf_rs_data,
    input  logic [DATA_W-1:0]       rf_rt_data,
    input  logic [DEPTH*DATA_W-1:0] slot_data,
    output logic                    stall,
    output logic [SEL_W-1:0]        fwd_rs_sel,
    output logic [SEL_W-1:0]        fwd_rt_sel,
    output logic [DATA_W-1:0]       rs_data,
    output logic [DATA_W-1:0]       rt_data,
    output logic [15:0]             stall_count
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [DEPTH-1:0]  r_valid_q,   w_valid_d;
    logic [DEPTH-1:0]  r_wr_en_q,   w_wr_en_d;
    logic [DEPTH-1:0]  r_is_load_q, w_is_load_d;
    logic [REG_AW-1:0] r_wr_reg_q [DEPTH];
    logic [REG_AW-1:0] w_wr_reg_d [DEPTH];
    logic [15:0]       r_stall_count_q, w_stall_count_d;

    logic              w_rs_hit, w_rt_hit, w_rs_load, w_rt_load;
    logic              w_rs_fwd, w_rt_fwd, w_rs_haz, w_rt_haz, w_stall;
    int                w_rs_idx, w_rt_idx;
    logic [DATA_W-1:0] w_rs_slot, w_rt_slot;

    // Scanning from the oldest slot down leaves the youngest match selected.
    always_comb begin
        w_rs_hit  = 1'b0;
        w_rs_idx  = 0;
        w_rs_load = 1'b0;
        w_rs_slot = '0;
        w_rt_hit  = 1'b0;
        w_rt_idx  = 0;
        w_rt_load = 1'b0;
        w_rt_slot = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_valid_q[k] && r_wr_en_q[k] && issue_rs_used &&
                (issue_rs != '0) && (r_wr_reg_q[k] == issue_rs)) begin
                w_rs_hit  = 1'b1;
                w_rs_idx  = k;
                w_rs_load = r_is_load_q[k];
                w_rs_slot = slot_data[k*DATA_W +: DATA_W];
            end
            if (r_valid_q[k] && r_wr_en_q[k] && issue_rt_used &&
                (issue_rt != '0) && (r_wr_reg_q[k] == issue_rt)) begin
                w_rt_hit  = 1'b1;
                w_rt_idx  = k;
                w_rt_load = r_is_load_q[k];
                w_rt_slot = slot_data[k*DATA_W +: DATA_W];
            end
        end
        w_rs_fwd = w_rs_hit && (w_rs_idx >= (w_rs_load ? LOAD_SLOT : RESULT_SLOT));
        w_rt_fwd = w_rt_hit && (w_rt_idx >= (w_rt_load ? LOAD_SLOT : RESULT_SLOT));
        w_rs_haz = w_rs_hit && !w_rs_fwd;
        w_rt_haz = w_rt_hit && !w_rt_fwd;
    end

    always_comb begin
        w_stall    = issue_valid && (w_rs_haz || w_rt_haz) && !flush;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        rs_data    = rf_rs_data;
        rt_data    = rf_rt_data;
        if (w_rs_fwd && !w_stall) begin
            fwd_rs_sel = SEL_W'(w_rs_idx + 1);
            rs_data    = w_rs_slot;
        end
        if (w_rt_fwd && !w_stall) begin
            fwd_rt_sel = SEL_W'(w_rt_idx + 1);
            rt_data    = w_rt_slot;
        end
    end

    assign stall       = w_stall;
    assign stall_count = r_stall_count_q;

    always_comb begin
        w_valid_d       = r_valid_q;
        w_wr_en_d       = r_wr_en_q;
        w_is_load_d     = r_is_load_q;
        w_wr_reg_d      = r_wr_reg_q;
        w_stall_count_d = r_stall_count_q;
        if (!hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                w_valid_d[k]   = r_valid_q[k-1];
                w_wr_en_d[k]   = r_wr_en_q[k-1];
                w_is_load_d[k] = r_is_load_q[k-1];
                w_wr_reg_d[k]  = r_wr_reg_q[k-1];
            end
            w_valid_d[0]   = issue_valid && !w_stall && !flush;
            w_wr_en_d[0]   = issue_wr_en;
            w_is_load_d[0] = issue_is_load;
            w_wr_reg_d[0]  = issue_wr_reg;
            // Branch kill applies to the post-shift view of the younger slots.
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k < BR_SLOT) begin
                        w_valid_d[k] = 1'b0;
                    end
                end
            end
            if (w_stall && (r_stall_count_q != C_CNT_MAX)) begin
                w_stall_count_d = r_stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q       <= '0;
            r_wr_en_q       <= '0;
            r_is_load_q     <= '0;
            r_stall_count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_wr_reg_q[k] <= '0;
            end
        end else begin
            r_valid_q       <= w_valid_d;
            r_wr_en_q       <= w_wr_en_d;
            r_is_load_q     <= w_is_load_d;
            r_wr_reg_q      <= w_wr_reg_d;
            r_stall_count_q <= w_stall_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_scoreboard
//  Brief    : Self-checking bench; directed scenarios plus randomized traffic
//             compared against a queue-based model of the in-flight window.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_scoreboard;

    localparam int C_DEPTH = 6;
    localparam int C_LOAD_SLOT = 1;
    localparam int C_RESULT_SLOT = 0;
    localparam int C_BR_SLOT = 2;

    logic clk = 1'b0;
    logic reset, hold, flush, issue_valid;
    logic [4:0] issue_rs, issue_rt, issue_wr_reg;
    logic issue_rs_used, issue_rt_used, issue_wr_en, issue_is_load;
    logic [31:0] rf_rs_data, rf_rt_data;
    logic [C_DEPTH*32-1:0] slot_data;
    logic [9*32-1:0] slot_data2;
    logic [32*32-1:0] slot_data3 = '0;

    logic stall, d_stall, s_stall;
    logic [2:0] fwd_rs_sel, fwd_rt_sel;
    logic [3:0] d_rs_sel, d_rt_sel;
    logic [5:0] s_rs_sel, s_rt_sel;
    logic [31:0] rs_data, rt_data, d_rs_data, d_rt_data, s_rs_data, s_rt_data;
    logic [15:0] stall_count, d_count, s_count;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used), .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg),
        .issue_is_load(issue_is_load), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .slot_data(slot_data), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .rs_data(rs_data), .rt_data(rt_data), .stall_count(stall_count)
    );

    pipe_hazard_scoreboard #(.DEPTH(9), .LOAD_SLOT(3), .SEL_W(4)) dut_deep (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used), .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg),
        .issue_is_load(issue_is_load), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .slot_data(slot_data2), .stall(d_stall), .fwd_rs_sel(d_rs_sel), .fwd_rt_sel(d_rt_sel),
        .rs_data(d_rs_data), .rt_data(d_rt_data), .stall_count(d_count)
    );

    // Long load latency makes a self-dependent load stall 31 of every 32 cycles.
    pipe_hazard_scoreboard #(.DEPTH(32), .LOAD_SLOT(31), .SEL_W(6)) dut_sat (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rs_used(issue_rs_used),
        .issue_rt_used(issue_rt_used), .issue_wr_en(issue_wr_en), .issue_wr_reg(issue_wr_reg),
        .issue_is_load(issue_is_load), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .slot_data(slot_data3), .stall(s_stall), .fwd_rs_sel(s_rs_sel), .fwd_rt_sel(s_rt_sel),
        .rs_data(s_rs_data), .rt_data(s_rt_data), .stall_count(s_count)
    );

    // ---------------- reference model: queue of in-flight instructions, [0] = youngest
    typedef struct packed {
        logic       valid;
        logic       wr_en;
        logic       is_load;
        logic [4:0] rd;
    } ent_t;

    ent_t m_q[$];
    int   m_count = 0;

    function automatic int youngest(input logic [4:0] src, input logic used);
        if (!used || src == 5'd0) return -1;
        foreach (m_q[i]) if (m_q[i].valid && m_q[i].wr_en && m_q[i].rd == src) return i;
        return -1;
    endfunction

    function automatic void mdl_eval(output logic e_stall, output logic [2:0] e_rs, output logic [2:0] e_rt);
        int  krs, krt;
        logic hz_rs, hz_rt;
        krs   = youngest(issue_rs, issue_rs_used);
        krt   = youngest(issue_rt, issue_rt_used);
        hz_rs = (krs >= 0) && (krs < (m_q[krs].is_load ? C_LOAD_SLOT : C_RESULT_SLOT));
        hz_rt = (krt >= 0) && (krt < (m_q[krt].is_load ? C_LOAD_SLOT : C_RESULT_SLOT));
        e_stall = issue_valid && (hz_rs || hz_rt) && !flush;
        e_rs = (krs >= 0 && !hz_rs && !e_stall) ? 3'(krs + 1) : 3'd0;
        e_rt = (krt >= 0 && !hz_rt && !e_stall) ? 3'(krt + 1) : 3'd0;
    endfunction

    logic       m_st;
    logic [2:0] m_a, m_b;
    ent_t       m_new;

    always @(posedge clk) begin
        if (reset) begin
            m_q = {};
            for (int i = 0; i < C_DEPTH; i++) m_q.push_back(ent_t'(0));
            m_count = 0;
        end else if (!hold) begin
            mdl_eval(m_st, m_a, m_b);
            if (m_st && m_count != 65535) m_count++;
            m_new = '0;
            if (issue_valid && !m_st && !flush) begin
                m_new.valid = 1'b1; m_new.wr_en = issue_wr_en;
                m_new.is_load = issue_is_load; m_new.rd = issue_wr_reg;
            end
            m_q.push_front(m_new);
            void'(m_q.pop_back());
            if (flush) for (int i = 0; i < C_BR_SLOT; i++) m_q[i].valid = 1'b0;
        end
    end

    // ---------------- stimulus helpers (no checking here)
    function automatic logic [31:0] sw(input int k);
        return slot_data[k*32 +: 32];
    endfunction

    task automatic rnd_data();
        for (int k = 0; k < C_DEPTH; k++) slot_data[k*32 +: 32] = $urandom;
        for (int k = 0; k < 9; k++) slot_data2[k*32 +: 32] = $urandom;
        rf_rs_data = $urandom;
        rf_rt_data = $urandom;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rs_used = 0; issue_rt_used = 0;
        issue_wr_en = 0; issue_wr_reg = 0; issue_is_load = 0; hold = 0; flush = 0;
    endtask

    task automatic drive_issue(input logic [4:0] rs, input logic rs_u, input logic [4:0] rt,
                               input logic rt_u, input logic wr, input logic [4:0] rd, input logic ld);
        issue_valid = 1; issue_rs = rs; issue_rs_used = rs_u; issue_rt = rt; issue_rt_used = rt_u;
        issue_wr_en = wr; issue_wr_reg = rd; issue_is_load = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        rnd_data();
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        reset = 1;
        issue_valid = 1; issue_rs = 5'($urandom); issue_rt = 5'($urandom);
        issue_rs_used = 1; issue_rt_used = 1; issue_wr_en = 1; issue_wr_reg = 5'($urandom);
        issue_is_load = 1; hold = 1'($urandom); flush = 0;
        rnd_data();
        tick();
        tick();
        @(negedge clk);
        n_cmp++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 7'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got stall/sel=%b want 0", {stall, fwd_rs_sel, fwd_rt_sel});
        end
        n_cmp++;
        if (rs_data !== rf_rs_data) begin
            n_fail++; $display("FAIL reset_rs_data: got %h want %h", rs_data, rf_rs_data);
        end
        n_cmp++;
        if ({stall_count, d_count, s_count} !== 48'd0) begin
            n_fail++; $display("FAIL reset_count: got %h/%h/%h want 0", stall_count, d_count, s_count);
        end
        reset = 0;
        idle();
        tick();
    endtask

    task automatic test_alu_forward();
        do_reset();
        drive_issue(0, 0, 0, 0, 1, 3, 0);
        tick();
        drive_issue(3, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({stall, fwd_rs_sel} !== {1'b0, 3'd1}) begin
            n_fail++; $display("FAIL alu_fwd_sel: got stall=%b sel=%0d want 0/1", stall, fwd_rs_sel);
        end
        n_cmp++;
        if (rs_data !== sw(0)) begin
            n_fail++; $display("FAIL alu_fwd_data: got %h want %h", rs_data, sw(0));
        end
        tick();
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_issue(0, 0, 0, 0, 1, 5, 1);
        tick();
        drive_issue(0, 0, 5, 1, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({stall, fwd_rt_sel} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL load_use_stall: got stall=%b sel=%0d want 1/0", stall, fwd_rt_sel);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({stall, fwd_rt_sel, rt_data, stall_count} !== {1'b0, 3'd2, sw(1), 16'd1}) begin
            n_fail++; $display("FAIL load_use_fwd: got stall=%b sel=%0d data=%h cnt=%0d want 0/2/%h/1",
                               stall, fwd_rt_sel, rt_data, stall_count, sw(1));
        end
        tick();
        idle();
    endtask

    task automatic test_youngest();
        do_reset();
        drive_issue(0, 0, 0, 0, 1, 7, 0); tick();
        drive_issue(0, 0, 0, 0, 1, 9, 0); tick();
        drive_issue(0, 0, 0, 0, 1, 9, 0); tick();
        drive_issue(0, 0, 0, 0, 1, 7, 0); tick();
        drive_issue(0, 0, 0, 0, 1, 0, 0); tick();
        drive_issue(7, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== {1'b0, 3'd2, 3'd0}) begin
            n_fail++; $display("FAIL youngest_sel: got stall=%b rs=%0d rt=%0d want 0/2/0", stall, fwd_rs_sel, fwd_rt_sel);
        end
        n_cmp++;
        if ({rs_data, rt_data} !== {sw(1), rf_rt_data}) begin
            n_fail++; $display("FAIL youngest_data: got %h %h want %h %h", rs_data, rt_data, sw(1), rf_rt_data);
        end
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        drive_issue(0, 0, 0, 0, 1, 2, 1);
        tick();
        drive_issue(2, 1, 0, 0, 0, 0, 0);
        flush = 1;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b want 0", stall);
        end
        tick();
        flush = 0;
        @(negedge clk);
        n_cmp++;
        if ({stall, fwd_rs_sel, rs_data, stall_count} !== {1'b0, 3'd0, rf_rs_data, 16'd0}) begin
            n_fail++; $display("FAIL flush_after: got stall=%b sel=%0d data=%h cnt=%0d want 0/0/%h/0",
                               stall, fwd_rs_sel, rs_data, stall_count, rf_rs_data);
        end
        tick();
        idle();
    endtask

    task automatic test_hold();
        do_reset();
        drive_issue(0, 0, 0, 0, 1, 5, 1);
        tick();
        drive_issue(0, 0, 5, 1, 0, 0, 0);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({stall, stall_count} !== {1'b1, 16'd0}) begin
                n_fail++; $display("FAIL hold_frozen[%0d]: got stall=%b cnt=%0d want 1/0", i, stall, stall_count);
            end
            tick();
        end
        hold = 0;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL hold_release_stall: got %b want 1", stall);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({stall, fwd_rt_sel, stall_count} !== {1'b0, 3'd2, 16'd1}) begin
            n_fail++; $display("FAIL hold_resolve: got stall=%b sel=%0d cnt=%0d want 0/2/1", stall, fwd_rt_sel, stall_count);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic       e_st;
        logic [2:0] e_rs, e_rt;
        logic [31:0] e_rsd, e_rtd;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_rs      = 5'($urandom_range(0, 3));
            issue_rt      = 5'($urandom_range(0, 3));
            issue_rs_used = 1'($urandom);
            issue_rt_used = 1'($urandom);
            issue_wr_en   = ($urandom_range(0, 3) != 0);
            issue_wr_reg  = 5'($urandom_range(0, 3));
            issue_is_load = 1'($urandom);
            hold          = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            rnd_data();
            @(negedge clk);
            mdl_eval(e_st, e_rs, e_rt);
            e_rsd = (e_rs == 0) ? rf_rs_data : sw(int'(e_rs) - 1);
            e_rtd = (e_rt == 0) ? rf_rt_data : sw(int'(e_rt) - 1);
            n_cmp++;
            if ({stall, fwd_rs_sel, fwd_rt_sel, rs_data, rt_data, stall_count} !==
                {e_st, e_rs, e_rt, e_rsd, e_rtd, 16'(m_count)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got st=%b rs=%0d rt=%0d %h %h cnt=%0d want st=%b rs=%0d rt=%0d %h %h cnt=%0d",
                         n, stall, fwd_rs_sel, fwd_rt_sel, rs_data, rt_data, stall_count,
                         e_st, e_rs, e_rt, e_rsd, e_rtd, m_count);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_deep_load();
        do_reset();
        drive_issue(0, 0, 0, 0, 1, 4, 1);
        tick();
        drive_issue(4, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (d_stall !== 1'b1) begin
                n_fail++; $display("FAIL deep_stall[%0d]: got %b want 1", i, d_stall);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if ({d_stall, d_rs_sel, d_rs_data, d_count} !== {1'b0, 4'd4, slot_data2[3*32 +: 32], 16'd3}) begin
            n_fail++; $display("FAIL deep_fwd: got stall=%b sel=%0d data=%h cnt=%0d want 0/4/%h/3",
                               d_stall, d_rs_sel, d_rs_data, d_count, slot_data2[3*32 +: 32]);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        drive_issue(5, 1, 0, 0, 1, 5, 1);
        repeat (33) tick();
        n_cmp++;
        if (s_count !== 16'd31) begin
            n_fail++; $display("FAIL sat_partial: got %0d want 31", s_count);
        end
        repeat (67800) @(posedge clk);
        #1;
        n_cmp++;
        if (s_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_reach: got %h want ffff", s_count);
        end
        repeat (64) tick();
        n_cmp++;
        if (s_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want ffff", s_count);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 0;
        rnd_data();
        tick();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_flush();
        test_hold();
        test_random();
        test_deep_load();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
